// File: rtl/idma_burst_gate.sv
// Write-burst gate behind the backend stream FIFO: holds a burst until all of its
// beats are buffered upstream, then releases them back-to-back with a last flag.
module idma_burst_gate #(
    parameter int unsigned LenWidth = 8,
    parameter int unsigned CntWidth = 9,
    parameter type         type_t   = logic
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [LenWidth-1:0] req_len_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  type_t               data_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    output type_t               data_o,
    output logic                data_last_o,
    output logic                data_valid_o,
    input  logic                data_ready_i,
    output logic                busy_o,
    output logic [CntWidth-1:0] avail_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM
    } state_e;

    state_e              state_q, state_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] beat_q, beat_d;
    logic [CntWidth-1:0] avail_q, avail_d;
    logic [CntWidth-1:0] need;
    logic                pop;
    logic                last_beat;

    // Beats required for the burst; CntWidth is wider than LenWidth so len+1 never wraps.
    assign need      = CntWidth'(len_q) + CntWidth'(1);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beat_d       = beat_q;
        req_ready_o  = 1'b0;
        data_valid_o = 1'b0;
        data_ready_o = 1'b0;
        data_last_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    len_d   = req_len_i;
                    beat_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (avail_q >= need) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                data_valid_o = data_valid_i;
                data_ready_o = data_ready_i;
                data_last_o  = last_beat;
                if (data_valid_i && data_ready_i) begin
                    beat_d = beat_q + LenWidth'(1);
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop = data_valid_o & data_ready_i;

    // Occupancy mirror of the upstream FIFO, updated from its push handshake and our pop.
    always_comb begin
        avail_d = avail_q;
        unique case ({push_i, pop})
            2'b10:   avail_d = avail_q + CntWidth'(1);
            2'b01:   avail_d = avail_q - CntWidth'(1);
            default: avail_d = avail_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            avail_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            avail_q <= avail_d;
        end
    end

    assign data_o  = data_i;
    assign busy_o  = (state_q != ST_IDLE);
    assign avail_o = avail_q;

    // Counter overflow would mean the FIFO is deeper than the counter can express.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !((&avail_q) && push_i && !pop));

    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        pop |-> (avail_q != '0));

    // Counter says beats are buffered but the FIFO shows none: the two are out of step.
    a_fifo_in_step : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        ((state_q == ST_STREAM) && (avail_q != '0)) |-> data_valid_i);

endmodule
